// File: rtl/sync_filter_pkg.sv
// Shared definitions for the multi-channel sync filter: per-channel FSM
// encoding and the saturating increment used by the glitch counters.
package sync_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_QUAL_HI = 2'b01,
    ST_ACTIVE  = 2'b10,
    ST_QUAL_LO = 2'b11
  } ch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync_filter_mc_if.sv
// Buffer-swap handshake between the sync filter and the frame-buffer controller.
interface sync_filter_mc_if;
  logic swap_req;
  logic swap_ack;
  logic swap_overrun;

  modport slave  (output swap_req, output swap_overrun, input swap_ack);
  modport master (input swap_req, input swap_overrun, output swap_ack);
endinterface

// File: rtl/sync_filter_ch.sv
// One sync channel: synchroniser, polarity normalisation, two-sided debounce
// FSM, edge pulses and a saturating count of rejected pulses.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 8,
  parameter int ASSERT_CYCLES   = 4,
  parameter int DEASSERT_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync_in_i,
  input  logic                polarity_i,
  input  logic                glitch_clr_i,
  output logic                sync_out_o,
  output logic                rise_pulse_o,
  output logic                fall_pulse_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam logic [31:0] GLITCH_MAX = 32'((64'd1 << GLITCH_W) - 64'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   glitch_inc;
  logic                   act;

  // A polarity flip is indistinguishable from an input edge by construction.
  assign act = sync_q[SYNC_STAGES-1] ~^ polarity_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: if (act) begin
        state_d = ST_QUAL_HI;
        cnt_d   = CNT_W'(1);
      end
      ST_QUAL_HI: begin
        if (!act) begin
          glitch_inc = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_W'(ASSERT_CYCLES)) begin
          state_d = ST_ACTIVE;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: if (!act) begin
        state_d = ST_QUAL_LO;
        cnt_d   = CNT_W'(1);
      end
      ST_QUAL_LO: begin
        if (act) begin
          glitch_inc = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ACTIVE;
        end else if (cnt_q == CNT_W'(DEASSERT_CYCLES)) begin
          state_d = ST_IDLE;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr_i)    glitch_d = '0;
    else if (glitch_inc) glitch_d = GLITCH_W'(sat_inc(32'(glitch_q), GLITCH_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sync_in_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign sync_out_o   = (state_q == ST_ACTIVE) || (state_q == ST_QUAL_LO);
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: rtl/sync_filter_mc.sv
// Multi-channel sync filter: per-channel debounce instances plus the
// channel-0 buffer-swap request/acknowledge handshake.
module sync_filter_mc
  import sync_filter_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 8,
  parameter int ASSERT_CYCLES   = 4,
  parameter int DEASSERT_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          sync_in,
  input  logic [NUM_CH-1:0]          polarity,
  output logic [NUM_CH-1:0]          sync_out,
  output logic [NUM_CH-1:0]          rise_pulse,
  output logic [NUM_CH-1:0]          fall_pulse,
  output logic [NUM_CH*GLITCH_W-1:0] glitch_cnt,
  input  logic                       glitch_clr,
  sync_filter_mc_if.slave            swap
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .CNT_W          (CNT_W),
      .ASSERT_CYCLES  (ASSERT_CYCLES),
      .DEASSERT_CYCLES(DEASSERT_CYCLES),
      .GLITCH_W       (GLITCH_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .sync_in_i   (sync_in[g]),
      .polarity_i  (polarity[g]),
      .glitch_clr_i(glitch_clr),
      .sync_out_o  (sync_out[g]),
      .rise_pulse_o(rise_pulse[g]),
      .fall_pulse_o(fall_pulse[g]),
      .glitch_cnt_o(glitch_cnt[g*GLITCH_W +: GLITCH_W])
    );
  end

  logic swap_req_q, swap_req_d;
  logic overrun_q, overrun_d;

  // A new rise beats a same-cycle ack: the old request is retired, the new one stays pending.
  always_comb begin
    swap_req_d = swap_req_q;
    if (rise_pulse[0])      swap_req_d = 1'b1;
    else if (swap.swap_ack) swap_req_d = 1'b0;
    overrun_d = overrun_q | (rise_pulse[0] & swap_req_q & ~swap.swap_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      swap_req_q <= swap_req_d;
      overrun_q  <= overrun_d;
    end
  end

  assign swap.swap_req     = swap_req_q;
  assign swap.swap_overrun = overrun_q;

endmodule
